// File: rtl/decimation_if.sv
// Sample stream bundle for the Rx decimation chain: ADC-rate input and decimated output.
interface decimation_if #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned OUT_W = 16
);
  logic                    in_valid;
  logic signed [IN_W-1:0]  in_sample;
  logic                    out_valid;
  logic signed [OUT_W-1:0] out_decimation;

  modport master (output in_valid, in_sample, input out_valid, out_decimation);
  modport slave  (input in_valid, in_sample, output out_valid, out_decimation);
endinterface

// File: rtl/decimation.sv
// Rx decimate-by-16: 3-stage CIC (R=8, M=1) followed by an 11-tap half-band decimator.
// Define DECIM_ROUND_EN for round-half-up before both scaling shifts (default: floor).
module decimation #(
  parameter int unsigned IN_W  = 12,
  parameter int unsigned CIC_W = 21,
  parameter int unsigned HB_W  = 15,
  parameter int unsigned OUT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  decimation_if.slave bus
);
  localparam int unsigned ACC_W   = 32;
  localparam int unsigned HB_TAPS = 11;
  localparam logic signed [ACC_W-1:0] C0 = ACC_W'(18);
  localparam logic signed [ACC_W-1:0] C2 = ACC_W'(-116);
  localparam logic signed [ACC_W-1:0] C4 = ACC_W'(610);
  localparam logic signed [ACC_W-1:0] C5 = ACC_W'(1024);
`ifdef DECIM_ROUND_EN
  localparam logic signed [CIC_W-1:0] CIC_HALF = CIC_W'(32);
  localparam logic signed [ACC_W-1:0] HB_HALF  = ACC_W'(1024);
`endif

  logic signed [CIC_W-1:0] int1, int2, int3;
  logic signed [CIC_W-1:0] comb1_d, comb2_d, comb3_d, cic_out;
  logic [2:0]              cic_phase;
  logic                    comb_trig, cic_valid, hb_phase, hb_eval;
  logic [HB_TAPS-1:0][HB_W-1:0] hb_line;

  logic signed [CIC_W-1:0] in_ext_c, int1_c, int2_c, int3_c;
  logic signed [CIC_W-1:0] comb1_c, comb2_c, comb3_c;
  logic signed [HB_W-1:0]  hb_in_c;
  logic signed [ACC_W-1:0] s0_c, s2_c, s4_c, mid_c, acc_c;
  logic signed [OUT_W-1:0] hb_out_c;

  function automatic logic signed [ACC_W-1:0] sx(input logic signed [HB_W-1:0] v);
    return {{(ACC_W-HB_W){v[HB_W-1]}}, v};
  endfunction

  // Datapath: integrator chain, comb chain, scaling and symmetric half-band MAC.
  always_comb begin
    in_ext_c = {{(CIC_W-IN_W){bus.in_sample[IN_W-1]}}, bus.in_sample};
    int1_c   = int1 + in_ext_c;
    int2_c   = int2 + int1_c;
    int3_c   = int3 + int2_c;
    comb1_c  = int3 - comb1_d;
    comb2_c  = comb1_c - comb2_d;
    comb3_c  = comb2_c - comb3_d;
`ifdef DECIM_ROUND_EN
    hb_in_c  = HB_W'((cic_out + CIC_HALF) >>> 6);
`else
    hb_in_c  = HB_W'(cic_out >>> 6);
`endif
    s0_c     = sx(hb_line[0]) + sx(hb_line[10]);
    s2_c     = sx(hb_line[2]) + sx(hb_line[8]);
    s4_c     = sx(hb_line[4]) + sx(hb_line[6]);
    mid_c    = sx(hb_line[5]);
    acc_c    = s0_c * C0 + s2_c * C2 + s4_c * C4 + mid_c * C5;
`ifdef DECIM_ROUND_EN
    hb_out_c = OUT_W'((acc_c + HB_HALF) >>> 11);
`else
    hb_out_c = OUT_W'(acc_c >>> 11);
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      int1               <= '0;
      int2               <= '0;
      int3               <= '0;
      comb1_d            <= '0;
      comb2_d            <= '0;
      comb3_d            <= '0;
      cic_out            <= '0;
      cic_phase          <= '0;
      comb_trig          <= 1'b0;
      cic_valid          <= 1'b0;
      hb_phase           <= 1'b0;
      hb_eval            <= 1'b0;
      hb_line            <= '0;
      bus.out_valid      <= 1'b0;
      bus.out_decimation <= '0;
    end else begin
      if (bus.in_valid) begin
        int1      <= int1_c;
        int2      <= int2_c;
        int3      <= int3_c;
        cic_phase <= cic_phase + 3'd1;
      end
      comb_trig <= bus.in_valid && (cic_phase == 3'd7);

      // Comb stage runs one cycle after the 8th sample reaches the integrators.
      cic_valid <= comb_trig;
      if (comb_trig) begin
        comb1_d <= int3;
        comb2_d <= comb1_c;
        comb3_d <= comb2_c;
        cic_out <= comb3_c;
      end

      // Half-band: shift every CIC output, evaluate after every odd one.
      hb_eval <= cic_valid && hb_phase;
      if (cic_valid) begin
        hb_line  <= {hb_line[HB_TAPS-2:0], hb_in_c};
        hb_phase <= ~hb_phase;
      end

      bus.out_valid <= hb_eval;
      if (hb_eval) begin
        bus.out_decimation <= hb_out_c;
      end
    end
  end
endmodule

// File: tb/tb_decimation.sv
// Randomized bench for decimation against a direct-form CIC/half-band convolution model.
module tb_decimation;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  decimation_if #(.IN_W(12), .OUT_W(16)) bus();

  decimation dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  typedef struct {
    longint cyc;
    longint val;
  } pulse_t;

  pulse_t pend[$];
  int     samples[$];
  longint h[22];
  longint hbc[11] = '{18, 0, -116, 0, 610, 1024, 610, 0, -116, 0, 18};
  int     checks   = 0;
  int     failures = 0;
  longint cyc      = 0;
  longint exp_val  = 0;
  bit     armed    = 1'b0;

  task automatic check_val(input string tag, input longint got, input longint expd);
    checks++;
    if (got != expd) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d cycle=%0d", tag, got, expd, cyc);
    end
  endtask

  // CIC output j: 22-tap triple-boxcar FIR over the accepted samples, decimated by 8.
  function automatic longint cic_model(input int j);
    longint s = 0;
    for (int m = 0; m < 22; m++) begin
      int n = 8 * j + 7 - m;
      if (n >= 0 && n < samples.size()) s += h[m] * longint'(samples[n]);
    end
    return s;
  endfunction

  function automatic longint hb_in_model(input int j);
    longint v;
    if (j < 0) return 0;
    v = cic_model(j);
`ifdef DECIM_ROUND_EN
    v = v + 32;
`endif
    v = v >>> 6;
    return ((v + 16384) & 32767) - 16384;
  endfunction

  function automatic longint out_model(input int k);
    longint acc = 0;
    for (int i = 0; i < 11; i++) acc += hbc[i] * hb_in_model(2 * k + 1 - i);
`ifdef DECIM_ROUND_EN
    acc = acc + 1024;
`endif
    return acc >>> 11;
  endfunction

  // One clock: check this cycle's outputs, then drive inputs for this cycle.
  task automatic step(input bit r, input bit v, input int x);
    bit exp_v;
    @(posedge clk);
    cyc++;
    #1;
    if (armed) begin
      exp_v = (pend.size() > 0) && (pend[0].cyc == cyc);
      check_val("out_valid", longint'(bus.out_valid), longint'(exp_v));
      if (exp_v) begin
        exp_val = pend[0].val;
        void'(pend.pop_front());
      end
      check_val("out_decimation", longint'(bus.out_decimation), exp_val);
    end
    rst          = r;
    bus.in_valid = v;
    bus.in_sample = 12'(x);
    if (r) begin
      samples.delete();
      pend.delete();
      exp_val = 0;
      armed   = 1'b1;
    end else if (v) begin
      int n = samples.size();
      samples.push_back(x);
      if (n % 16 == 15) pend.push_back('{cyc + 4, out_model(n / 16)});
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 0);
  endtask

  initial begin
    for (int a = 0; a < 8; a++)
      for (int b = 0; b < 8; b++)
        for (int c = 0; c < 8; c++) h[a + b + c]++;
    rst = 1'b1;
    bus.in_valid  = 1'b0;
    bus.in_sample = '0;

    // Reset held with toggling in_valid, then a short random burst.
    for (int i = 0; i < 3; i++) step(1'b1, 1'(i % 2), 700);
    for (int i = 0; i < 40; i++) step(1'b0, 1'b1, int'($urandom_range(0, 4095)) - 2048);
    idle(6);

    // DC at full rate.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 320; i++) step(1'b0, 1'b1, 1000);
    idle(6);
    check_val("dc1000", longint'(bus.out_decimation), 8000);

    // Gapped DC, one valid in three.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 160; i++) begin
      step(1'b0, 1'b1, 1000);
      idle(2);
    end
    idle(6);
    check_val("gapped1000", longint'(bus.out_decimation), 8000);

    // Reset after 23 samples, then a fresh DC run.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 23; i++) step(1'b0, 1'b1, 1000);
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 320; i++) step(1'b0, 1'b1, 1000);
    idle(6);
    check_val("dc_after_reset", longint'(bus.out_decimation), 8000);

    // Impulse response.
    step(1'b1, 1'b0, 0);
    step(1'b0, 1'b1, 1000);
    for (int i = 0; i < 300; i++) step(1'b0, 1'b1, 0);
    idle(6);
    check_val("impulse_tail", longint'(bus.out_decimation), 0);

    // Random samples with random gaps.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 3000; i++)
      step(1'b0, 1'($urandom_range(0, 3) != 0), int'($urandom_range(0, 4095)) - 2048);
    idle(6);

    // Extremes long enough to wrap the integrators.
    step(1'b1, 1'b0, 0);
    for (int i = 0; i < 6000; i++) step(1'b0, 1'b1, 2047);
    idle(6);
    check_val("max_dc", longint'(bus.out_decimation), 16376);
    for (int i = 0; i < 6000; i++) step(1'b0, 1'b1, -2048);
    idle(6);
    check_val("min_dc", longint'(bus.out_decimation), -16384);

    idle(4);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/decimation.md
# decimation

Receive-path decimation chain, the Rx counterpart of the Tx interpolation chain. It takes 12-bit signed ADC-rate samples and decimates by 16: a 3-stage CIC decimator (R=8, M=1) is followed by an 11-tap half-band decimator (÷2). Everything runs on a single clock, and rate changes are carried by valid strobes rather than derived clocks. It sits between the ADC sample register and the Rx baseband demodulator.

## Interface
- `IN_W`, 12: input sample width (signed).
- `CIC_W`, 21: CIC register width, equal to IN_W + 3·log2(8).
- `HB_W`, 15: half-band input width.
- `OUT_W`, 16: output width (signed).
- `clk` input 1: single system clock; all logic is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: qualifies `in_sample`; one sample is accepted per high cycle.
- `in_sample` input IN_W: signed ADC sample.
- `out_valid` output 1: one-cycle pulse per decimated output.
- `out_decimation` output OUT_W: signed decimated sample, held between pulses.

## Operation
- **Reset** (on `rst` high at a clock edge): the following all clear to 0.
  - Integrators, comb delays, HB delay line, phase counters and accumulators.
  - `out_valid` = 0 and `out_decimation` = 0.
- **CIC integrators**
  - Three cascaded CIC_W-bit accumulators.
  - They update only on `in_valid` cycles; `in_sample` is sign-extended.
  - Arithmetic is modular two's complement, so wrap-around is intentional and required.
- **CIC decimation phase**
  - 3-bit counter that increments on each accepted sample and wraps 7→0.
  - The sample accepted with count 7 triggers a comb update.
- **Comb stages**
  - Three differentiators with M=1, CIC_W bits, modular arithmetic, registered.
  - They produce `cic_valid` and `cic_out` 2 cycles after the triggering `in_valid` cycle.
- **CIC scaling**
  - HB input = `cic_out` >>> 6 (arithmetic), truncated to HB_W bits.
  - The CIC DC gain of 512 becomes a net gain of 8.
- **Half-band filter**
  - 11-entry HB_W delay line that shifts on every `cic_valid`.
  - Integer coefficients: [18, 0, −116, 0, 610, 1024, 610, 0, −116, 0, 18], with sum 2048.
  - Uses a symmetric pre-add; zero taps are not computed.
  - The accumulator is at least 29 bits signed.
- **HB decimation phase**
  - A 1-bit toggle on each `cic_valid`.
  - The filter is evaluated only when the phase was 1, i.e. on odd CIC outputs.
  - Result = acc >>> 11, fitting OUT_W without overflow.
- **Output**
  - Registered into `out_decimation` together with a one-cycle `out_valid`.
- **Gaps in `in_valid`**: all state holds; there is no timeout and no flush.
- **Simultaneous events**: a `cic_valid` coinciding with a new `in_valid` is handled independently, because the pipelines are decoupled.
- **Reset mid-operation**: in-flight results are discarded, with no `out_valid` after reset until 16 new samples.

## Timing
- Samples are indexed from reset as 0, 1, 2, …
- CIC output j covers samples up to 8j+7.
- Output k is produced from CIC output 2k+1.
- `out_valid` pulses exactly 4 cycles after the `in_valid` cycle carrying sample 16k+15.
- The latency budget is 2 cycles CIC plus 2 cycles HB.
- At most one `out_valid` occurs per 16 accepted samples, and `out_valid` is never high on consecutive cycles.
- `in_valid` may be high every cycle; the block is fully pipelined with no backpressure.

## Configuration
- **`DECIM_ROUND_EN` defined**: round-half-up is applied before both shifts.
  - CIC: add 2^5 before >>>6.
  - HB: add 2^10 before >>>11.
- **`DECIM_ROUND_EN` undefined**: plain arithmetic-shift truncation (floor).
- Latency and handshakes are identical in both builds.
- DC test values below are exact in both builds.

## Test plan
- **Reset**
  - Stimulus: hold `rst` high for 3 cycles with `in_valid` toggling.
  - Required response: `out_valid` = 0 and `out_decimation` = 0 throughout.
  - After release, the first `out_valid` comes exactly 4 cycles after the 16th accepted sample.
- **DC at full rate**
  - Stimulus: `in_sample` = 1000 with `in_valid` = 1 continuously.
  - Required response: after settling (≥ 3 CIC + HB fill), `out_decimation` = 8000 on every pulse.
  - Pulses are spaced exactly 16 cycles apart.
- **Extremes**
  - Constant 2047 → settled output 16376.
  - Constant −2048 → settled output −16384.
  - Run more than 10^4 samples so the integrators wrap; no glitches are allowed.
- **Gapped input**
  - Stimulus: DC 1000 with `in_valid` high 1 cycle in 3.
  - Required response: output 8000.
  - Pulses occur every 48 cycles, 4 cycles after each 16th accepted sample.
- **Reset mid-run**
  - Stimulus: assert `rst` for 1 cycle after 23 accepted samples of DC 1000.
  - Required response: no pulse fires from the pre-reset samples.
  - Post-reset output matches a fresh run, including the transient sequence.
- **Impulse**
  - Stimulus: a single sample of 1000 followed by zeros, at full rate.
  - Required response: the output sequence matches the bit-exact golden model (CIC→>>>6→HB→>>>11) for both macro settings.
  - The sequence returns to 0 and stays there.
